chan_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/chan_arbiter.sv | 165 ++++++++++++++++
 tb/tb_chan_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg
// Shared definitions for the round-robin channel arbiter.
//   - arb_state_e : arbiter state encoding (IDLE=0, GRANT=1, RELEASE=2)
//   - DEF_NREQ    : default number of requesters
//   - DEF_MAXHOLD : default maximum grant length when the timeout is built in
//   - id_width()  : number of bits needed to index n items (at least 1)
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_MAXHOLD = 8;

    // Index width for n items; a single item still needs one bit of storage.
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick
// Combinational rotate-priority picker. Scans i_req upward starting at i_ptr,
// wrapping modulo NREQ, and reports the first set bit.
//
// Ports
//   i_req    [NREQ-1:0]  request vector
//   i_ptr    [IW-1:0]    index with highest priority this cycle
//   o_winner [IW-1:0]    index of the selected requester (0 when none)
//   o_valid              at least one request is set
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_winner,
    output logic            o_valid
);

    int w_idx;

    // First set request at or above the pointer, wrapping around the vector.
    always_comb begin
        o_winner = {IW{1'b0}};
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(i_ptr) + i) % NREQ;
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = IW'(w_idx);
            end else begin
                o_valid  = o_valid;
                o_winner = o_winner;
            end
        end
    end

endmodule

// File: rtl/chan_arbiter.sv
// ============================================================================
// chan_arbiter
// Round-robin arbiter that hands a single-bit pass-through channel to one of
// NREQ requesters at a time. The granted requester's din bit is routed to
// dout with zero latency while busy is high. Every ownership change passes
// through a one-cycle RELEASE state in which nobody drives the channel.
//
// Compile-time option
//   ARB_TIMEOUT_EN : when defined, a grant is forcibly ended after MAXHOLD
//                    cycles. When undefined there is no hold counter and the
//                    owner keeps the channel until it drops req or pulses
//                    done; MAXHOLD is then ignored.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   req   [NREQ-1:0] : request levels, held high until released
//   done  [NREQ-1:0] : release pulses, only the owner's bit counts
//   din   [NREQ-1:0] : per-requester data bits
//   gnt   [NREQ-1:0] : one-hot grant (registered)
//   busy             : channel owned this cycle (registered)
//   owner [IW-1:0]   : current or most recent owner (registered)
//   dout             : din[owner] while busy, else 0 (combinational)
// ============================================================================
module chan_arbiter
    import arb_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int MAXHOLD = DEF_MAXHOLD,
    localparam int IW      = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [IW-1:0]   owner,
    output logic            dout
);

    arb_state_e      r_state;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;

    logic [IW-1:0]   w_winner;
    logic            w_valid;
    logic [IW-1:0]   w_next_ptr;
    logic [NREQ-1:0] w_onehot;
    logic            w_own_req;
    logic            w_own_done;
    logic            w_timeout;
    logic            w_release;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // The slot after the winner gets top priority next time, so the
    // outgoing owner automatically ranks last when RELEASE re-arbitrates.
    assign w_next_ptr = (w_winner == IW'(NREQ - 1)) ? {IW{1'b0}}
                                                    : (w_winner + {{(IW-1){1'b0}}, 1'b1});
    assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

    // Only the owner's request and done bits can end a grant.
    assign w_own_req  = req[r_owner];
    assign w_own_done = done[r_owner];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = id_width(MAXHOLD);

    logic [HW-1:0] r_hold;

    // Counter reaches MAXHOLD-1 in the last allowed cycle of a grant.
    assign w_timeout = (r_hold == HW'(MAXHOLD - 1));

    // Hold counter: cleared on every new grant, counts grant cycles, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= {HW{1'b0}};
        end else if ((r_state != GRANT) && w_valid) begin
            r_hold <= {HW{1'b0}};
        end else if ((r_state == GRANT) && !w_release && (r_hold != {HW{1'b1}})) begin
            r_hold <= r_hold + {{(HW-1){1'b0}}, 1'b1};
        end else begin
            r_hold <= r_hold;
        end
    end
`else
    logic w_unused_cfg;

    // Without the timeout option a grant only ends voluntarily.
    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (MAXHOLD == 0);
`endif

    // Timeout coinciding with a voluntary release takes the same path.
    assign w_release = !w_own_req || w_own_done || w_timeout;

    // Arbiter FSM with registered grant, busy, owner and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= {NREQ{1'b0}};
            r_busy  <= 1'b0;
            r_owner <= {IW{1'b0}};
            r_ptr   <= {IW{1'b0}};
        end else begin
            case (r_state)
                IDLE, RELEASE: begin
                    if (w_valid) begin
                        r_state <= GRANT;
                        r_gnt   <= w_onehot;
                        r_busy  <= 1'b1;
                        r_owner <= w_winner;
                        r_ptr   <= w_next_ptr;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= {NREQ{1'b0}};
                        r_busy  <= 1'b0;
                        r_owner <= r_owner;
                        r_ptr   <= r_ptr;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        // One dead cycle so two drivers never overlap on the wire.
                        r_state <= RELEASE;
                        r_gnt   <= {NREQ{1'b0}};
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= GRANT;
                        r_gnt   <= r_gnt;
                        r_busy  <= 1'b1;
                    end
                    r_owner <= r_owner;
                    r_ptr   <= r_ptr;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                    r_owner <= {IW{1'b0}};
                    r_ptr   <= {IW{1'b0}};
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign busy  = r_busy;
    assign owner = r_owner;

    // Zero-latency channel: the busy gate is the only thing between din and dout.
    assign dout  = r_busy & din[r_owner];

endmodule

// File: tb/tb_chan_arbiter.sv
// ============================================================================
// tb_chan_arbiter
// Bench for chan_arbiter (NREQ=4, MAXHOLD=8). A small behavioural model tracks
// who owns the channel and for how long; a compare process checks every
// output against it on each falling clock edge. Directed scenarios add
// literal expectations, then a randomized run exercises the model.
// Builds with or without ARB_TIMEOUT_EN.
// ============================================================================
module tb_chan_arbiter;

    localparam int NREQ    = 4;
    localparam int MAXHOLD = 8;
    localparam int IW      = 2;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] din;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [IW-1:0]   owner;
    logic            dout;

    chan_arbiter #(
        .NREQ    (NREQ),
        .MAXHOLD (MAXHOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .done  (done),
        .din   (din),
        .gnt   (gnt),
        .busy  (busy),
        .owner (owner),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The channel is either owned (m_busy) or free. A free channel is handed
    // to the first requester at or after m_ptr on the next edge; an owned
    // one is given up when the owner lets go (or has held it MAXHOLD cycles).
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;

    function automatic int pick_winner(input logic [NREQ-1:0] r, input int from);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit rel;
        int w;
        if (rst) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_busy) begin
            rel = !req[m_owner] || done[m_owner];
`ifdef ARB_TIMEOUT_EN
            if (m_hold >= MAXHOLD) rel = 1'b1;
`endif
            if (rel) m_busy = 1'b0;
            else     m_hold = m_hold + 1;
        end else begin
            w = pick_winner(req, m_ptr);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_ptr   = (w + 1) % NREQ;
                m_hold  = 1;
            end
        end
    end

    // Compare process: all outputs against the model every cycle.
    always @(negedge clk) begin
        chk("gnt",   32'(gnt),   m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("busy",  32'(busy),  32'(m_busy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("dout",  32'(dout),  m_busy ? 32'(din[m_owner]) : 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        #1;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_dout",  32'(dout),  32'd0);
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = '0;
        din  = '0;
        step(2);
        chk("init_gnt",   32'(gnt),   32'd0);
        chk("init_busy",  32'(busy),  32'd0);
        chk("init_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        step(1);

        // Single requester, zero-latency data path.
        req = 4'b0100;
        din = 4'b0100;
        step(1);
        chk("t1_gnt",   32'(gnt),   32'h4);
        chk("t1_owner", 32'(owner), 32'd2);
        chk("t1_dout",  32'(dout),  32'd1);
        din = 4'b0000;
        #1;
        chk("t1_dout_lo", 32'(dout), 32'd0);
        din = 4'b0100;
        #1;
        chk("t1_dout_hi", 32'(dout), 32'd1);
        req = 4'b0000;
        step(1);
        chk("t1_rel_busy", 32'(busy), 32'd0);
        step(1);

        // All request: rotation 0,1,2,3,0 with one dead cycle between grants.
        do_reset();
        din = 4'b1111;
        req = 4'b1111;
        step(1);
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", 32'(gnt), 32'd1 << (k % 4));
            step(1);
            chk("rr_owner", 32'(owner), 32'(k % 4));
            chk("rr_busy",  32'(busy),  32'd1);
            req[k % 4] = 1'b0;
            step(1);
            chk("rr_dead_gnt",  32'(gnt),  32'd0);
            chk("rr_dead_dout", 32'(dout), 32'd0);
            req[k % 4] = 1'b1;
            step(1);
        end

`ifdef ARB_TIMEOUT_EN
        // Timeout: each grant lasts exactly MAXHOLD cycles.
        do_reset();
        req = 4'b0011;
        step(1);
        for (int c = 0; c < MAXHOLD; c++) begin
            chk("to_owner0", 32'(owner), 32'd0);
            chk("to_busy0",  32'(busy),  32'd1);
            step(1);
        end
        chk("to_rel0", 32'(busy), 32'd0);
        step(1);
        for (int c = 0; c < MAXHOLD; c++) begin
            chk("to_owner1", 32'(owner), 32'd1);
            chk("to_busy1",  32'(busy),  32'd1);
            step(1);
        end
        chk("to_rel1", 32'(busy), 32'd0);
`else
        // No timeout: owner 3 keeps the channel with req[0] pending.
        do_reset();
        req = 4'b1000;
        step(1);
        chk("nt_owner_first", 32'(owner), 32'd3);
        req = 4'b1001;
        for (int c = 0; c < 50; c++) begin
            step(1);
            chk("nt_owner", 32'(owner), 32'd3);
            chk("nt_busy",  32'(busy),  32'd1);
        end
`endif

        // done from a non-owner is ignored; the owner's done releases.
        do_reset();
        req = 4'b0001;
        step(1);
        chk("dn_owner", 32'(owner), 32'd0);
        done = 4'b0010;
        step(1);
        done = 4'b0000;
        chk("dn_other_busy", 32'(busy), 32'd1);
        done = 4'b0001;
        step(1);
        done = 4'b0000;
        chk("dn_rel_busy", 32'(busy), 32'd0);
        chk("dn_rel_gnt",  32'(gnt),  32'd0);
        step(1);
        chk("dn_sole_owner", 32'(owner), 32'd0);
        chk("dn_sole_busy",  32'(busy),  32'd1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        step(2);
        chk("ar_owner", 32'(owner), 32'd2);
        rst = 1'b1;
        #1;
        chk("ar_gnt",  32'(gnt),  32'd0);
        chk("ar_dout", 32'(dout), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        req = 4'b0101;
        step(1);
        rst = 1'b0;
        step(1);
        chk("ar_after_owner", 32'(owner), 32'd0);
        chk("ar_after_gnt",   32'(gnt),   32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : '0;
            din  = NREQ'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
